reg_rw_arbiter: RTL and testbench
=================================

Name: reg_rw_arbiter

Overview:
Multi-channel successor to the single-channel read/write control handshake. It accepts write/read request pulses from N_CH controller ports and latches each one with its address and data. Channels are served round-robin onto one register-bus port, with level strobes held until acknowledged. A per-transaction timeout returns an error ack when the register side never responds. The block sits between the configuration controllers and the register bank, inside one clock domain.

Parameters:
N_CH, 4, number of controller channels (>=2)
AW, 20, address width
DW, 32, data width
TO_W, 8, timeout counter width
TIMEOUT, 255, BUSY cycles without ack before error completion; 0 disables timeout

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
ctrl_we_i  in  N_CH  per-channel write request pulse
ctrl_re_i  in  N_CH  per-channel read request pulse
ctrl_addr_i  in  N_CH*AW  per-channel address, channel c at [c*AW +: AW]
ctrl_wdata_i  in  N_CH*DW  per-channel write data, channel c at [c*DW +: DW]
ctrl_ack_o  out  N_CH  one-cycle completion pulse per channel
ctrl_err_o  out  N_CH  one-cycle timeout flag, coincident with ack
ctrl_rdata_o  out  DW  read data of last completed transaction
reg_we_o  out  1  register write strobe (level)
reg_re_o  out  1  register read strobe (level)
reg_addr_o  out  AW  register address
reg_wdata_o  out  DW  register write data
reg_rdata_i  in  DW  register read data, valid with reg_ack_i
reg_ack_i  in  1  register access done
busy_o  out  1  FSM in BUSY

Behaviour:
- Reset (rstn_i low, async): all outputs 0, all pending flags cleared, FSM IDLE, RR pointer = N_CH-1 so channel 0 is served first. An in-flight transaction is dropped without ack.
- Per-channel latch: on a we or re pulse while the channel is not pending, set pending and capture addr, wdata and type. we wins if we and re are high together. A pulse while pending is ignored; the latched request is unchanged.
- FSM IDLE: if any channel is pending, grant the first pending channel searching cyclically from pointer+1. On the clock edge: load reg_addr_o/reg_wdata_o, assert reg_we_o or reg_re_o, pointer := granted, clear timeout counter, go BUSY.
- FSM BUSY: strobe and address/data stay constant. The counter increments each cycle.
  - reg_ack_i=1: next cycle strobe=0, ctrl_ack_o[g]=1 for one cycle, pending[g] cleared, ctrl_rdata_o := reg_rdata_i (reads only; unchanged on writes), go IDLE.
  - Timeout: TIMEOUT!=0 and counter==TIMEOUT-1 with no ack. Next cycle the same as an ack, plus ctrl_err_o[g]=1, and ctrl_rdata_o := 0 for reads.
  - Ack and timeout in the same cycle: ack wins, no error.
- reg_ack_i in IDLE: ignored.
- Latency with reg_ack_i tied high: pulse at cycle 0 -> pending at 1 -> strobe at 2 -> ack sampled at 2 -> ctrl_ack_o at 3. Next grant strobes at 4 at the earliest (one IDLE cycle between transactions).
- A new pulse on a channel in its ack cycle is accepted, because pending was cleared at that edge.
- Counter width is TO_W. TIMEOUT must be < 2**TO_W; the counter saturates and never wraps.

Test Plan:
- Single write: ch1 we pulse, addr 0x00010, wdata 0xA5A5A5A5, ack tied 1 -> reg_we_o high cycle 2 only with those values; ctrl_ack_o=4'b0010 cycle 3; err 0.
- Read: ch2 re pulse, reg_ack_i asserted after 5 BUSY cycles with rdata 0x12345678 -> reg_re_o high 5 cycles, ctrl_ack_o[2] pulse, ctrl_rdata_o=0x12345678.
- Round robin: pulses on ch0–3 in the same cycle, ack tied 1 -> grants 0,1,2,3 on cycles 2,4,6,8; then ch0 and ch3 requested again after ch0 was last served -> ch3 served before ch0.
- Timeout: TIMEOUT=10, ch0 read, reg_ack_i never asserted -> strobe high exactly 10 cycles; ctrl_ack_o[0] and ctrl_err_o[0] pulse together; ctrl_rdata_o=0. Ack on cycle 10 instead -> no err.
- Re-pulse while pending: ch1 we addr A, then ch1 we addr B before grant -> only addr A issued, exactly one ack.
- Async reset mid-BUSY: rstn_i low mid-transaction -> strobes and outputs 0 immediately; no ack after release; a fresh ch0 request completes normally.

Source files
------------

// File: rtl/reg_rw_arbiter_if.sv
// Controller-side and register-side signals of reg_rw_arbiter, bundled as one interface.
// The arbiter connects through the slave modport; its environment drives the master side.
interface reg_rw_arbiter_if #(
   parameter int N_CH = 4,
   parameter int AW   = 20,
   parameter int DW   = 32
);
   logic [N_CH-1:0]    ctrl_we_i;
   logic [N_CH-1:0]    ctrl_re_i;
   logic [N_CH*AW-1:0] ctrl_addr_i;
   logic [N_CH*DW-1:0] ctrl_wdata_i;
   logic [N_CH-1:0]    ctrl_ack_o;
   logic [N_CH-1:0]    ctrl_err_o;
   logic [DW-1:0]      ctrl_rdata_o;
   logic               reg_we_o;
   logic               reg_re_o;
   logic [AW-1:0]      reg_addr_o;
   logic [DW-1:0]      reg_wdata_o;
   logic [DW-1:0]      reg_rdata_i;
   logic               reg_ack_i;
   logic               busy_o;

   modport slave (
      input  ctrl_we_i, ctrl_re_i, ctrl_addr_i, ctrl_wdata_i, reg_rdata_i, reg_ack_i,
      output ctrl_ack_o, ctrl_err_o, ctrl_rdata_o, reg_we_o, reg_re_o, reg_addr_o,
             reg_wdata_o, busy_o
   );

   modport master (
      output ctrl_we_i, ctrl_re_i, ctrl_addr_i, ctrl_wdata_i, reg_rdata_i, reg_ack_i,
      input  ctrl_ack_o, ctrl_err_o, ctrl_rdata_o, reg_we_o, reg_re_o, reg_addr_o,
             reg_wdata_o, busy_o
   );
endinterface

// File: rtl/reg_rw_arbiter.sv
// Round-robin arbiter from N_CH request-pulse controller ports onto one level-strobe
// register bus, with per-transaction timeout producing an error completion.
module reg_rw_arbiter #(
   parameter int N_CH    = 4,
   parameter int AW      = 20,
   parameter int DW      = 32,
   parameter int TO_W    = 8,
   parameter int TIMEOUT = 255
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   reg_rw_arbiter_if.slave bus
);
   localparam int              PW      = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [PW-1:0]   PTR_RST = PW'(N_CH - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [N_CH-1:0] r_pend;
   logic [N_CH-1:0] r_is_wr;
   logic [AW-1:0]   r_addr  [N_CH];
   logic [DW-1:0]   r_wdata [N_CH];

   logic [PW-1:0]   r_ptr;
   logic [TO_W-1:0] r_cnt;
   logic [N_CH-1:0] r_ack;
   logic [N_CH-1:0] r_err;
   logic [DW-1:0]   r_rdata;
   logic            r_reg_we;
   logic            r_reg_re;
   logic [AW-1:0]   r_reg_addr;
   logic [DW-1:0]   r_reg_wdata;

   logic            w_gnt_found;
   logic [PW-1:0]   w_gnt_idx;
   logic [PW-1:0]   w_scan_idx;
   int              w_scan_sum;
   logic            w_start;
   logic            w_finish;
   logic            w_to_hit;

   // Ack wins over timeout: the timeout only fires when no ack is present this cycle.
   assign w_to_hit = (TIMEOUT != 0) && (r_cnt == TO_LAST) && !bus.reg_ack_i;

   // Cyclic search for the first pending channel after the last granted one.
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_idx   = r_ptr;
      w_scan_sum  = 0;
      w_scan_idx  = '0;
      for (int i = 1; i <= N_CH; i++) begin
         w_scan_sum = int'(r_ptr) + i;
         w_scan_idx = (w_scan_sum >= N_CH) ? PW'(w_scan_sum - N_CH) : PW'(w_scan_sum);
         if (!w_gnt_found && r_pend[w_scan_idx]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = w_scan_idx;
         end else begin
            w_gnt_idx   = w_gnt_idx;
         end
      end
   end

   // Next-state logic: grant from IDLE, complete from BUSY on ack or timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_found) begin
               w_start     = 1'b1;
               w_state_nxt = ST_BUSY;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (bus.reg_ack_i || w_to_hit) begin
               w_finish    = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_BUSY;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Per-channel request latch; a pulse on an already pending channel is dropped.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_pend  <= '0;
         r_is_wr <= '0;
         for (int c = 0; c < N_CH; c++) begin
            r_addr[c]  <= '0;
            r_wdata[c] <= '0;
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (!r_pend[c] && (bus.ctrl_we_i[c] || bus.ctrl_re_i[c])) begin
               r_pend[c]  <= 1'b1;
               r_is_wr[c] <= bus.ctrl_we_i[c];
               r_addr[c]  <= bus.ctrl_addr_i[c*AW +: AW];
               r_wdata[c] <= bus.ctrl_wdata_i[c*DW +: DW];
            end else if (w_finish && (r_ptr == PW'(c))) begin
               r_pend[c]  <= 1'b0;
            end
         end
      end
   end

   // Register-bus strobes, completion pulses, read data and the timeout counter.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_ptr       <= PTR_RST;
         r_cnt       <= '0;
         r_ack       <= '0;
         r_err       <= '0;
         r_rdata     <= '0;
         r_reg_we    <= 1'b0;
         r_reg_re    <= 1'b0;
         r_reg_addr  <= '0;
         r_reg_wdata <= '0;
      end else begin
         r_ack <= '0;
         r_err <= '0;
         if (w_start) begin
            r_reg_we    <= r_is_wr[w_gnt_idx];
            r_reg_re    <= !r_is_wr[w_gnt_idx];
            r_reg_addr  <= r_addr[w_gnt_idx];
            r_reg_wdata <= r_wdata[w_gnt_idx];
            r_ptr       <= w_gnt_idx;
            r_cnt       <= '0;
         end else if (w_finish) begin
            r_reg_we     <= 1'b0;
            r_reg_re     <= 1'b0;
            r_ack[r_ptr] <= 1'b1;
            r_err[r_ptr] <= !bus.reg_ack_i;
            if (r_reg_re) begin
               r_rdata <= bus.reg_ack_i ? bus.reg_rdata_i : '0;
            end
         end else if ((r_state == ST_BUSY) && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.ctrl_ack_o   = r_ack;
   assign bus.ctrl_err_o   = r_err;
   assign bus.ctrl_rdata_o = r_rdata;
   assign bus.reg_we_o     = r_reg_we;
   assign bus.reg_re_o     = r_reg_re;
   assign bus.reg_addr_o   = r_reg_addr;
   assign bus.reg_wdata_o  = r_reg_wdata;
   assign bus.busy_o       = (r_state == ST_BUSY);

endmodule

// File: tb/tb_reg_rw_arbiter.sv
// Scenario tasks with inline checks, then a randomized run against a transaction-level model.
module tb_reg_rw_arbiter;
   localparam int N_CH    = 4;
   localparam int AW      = 20;
   localparam int DW      = 32;
   localparam int TO_W    = 8;
   localparam int TIMEOUT = 10;

   logic clk;
   logic rstn;
   int   n_pass  = 0;
   int   n_total = 0;

   reg_rw_arbiter_if #(.N_CH(N_CH), .AW(AW), .DW(DW)) bus ();

   reg_rw_arbiter #(.N_CH(N_CH), .AW(AW), .DW(DW), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model state
   bit            m_pend [N_CH];
   bit            m_wr   [N_CH];
   logic [AW-1:0] m_addr [N_CH];
   logic [DW-1:0] m_wd   [N_CH];

   function automatic int pick(int ptr);
      for (int i = 1; i <= N_CH; i++) begin
         if (m_pend[(ptr + i) % N_CH]) return (ptr + i) % N_CH;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ctrl_we_i    = '0;
      bus.ctrl_re_i    = '0;
      bus.ctrl_addr_i  = '0;
      bus.ctrl_wdata_i = '0;
      bus.reg_rdata_i  = '0;
      bus.reg_ack_i    = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rstn = 1'b0;
      repeat (2) tick();
      rstn = 1'b1;
      tick();
   endtask

   task automatic wait_grant(output logic [AW-1:0] addr, output bit found);
      found = 1'b0;
      addr  = '0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (bus.reg_we_o || bus.reg_re_o) begin
            found = 1'b1;
            addr  = bus.reg_addr_o;
         end
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rstn = 1'b1;
      #2;
      rstn = 1'b0;
      #1;
      n_total++; if (bus.ctrl_ack_o !== 4'b0000) $display("FAIL rst_ack got=%b exp=0000", bus.ctrl_ack_o); else n_pass++;
      n_total++; if (bus.ctrl_err_o !== 4'b0000) $display("FAIL rst_err got=%b exp=0000", bus.ctrl_err_o); else n_pass++;
      n_total++; if (bus.ctrl_rdata_o !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", bus.ctrl_rdata_o); else n_pass++;
      n_total++; if (bus.reg_we_o !== 1'b0) $display("FAIL rst_we got=%b exp=0", bus.reg_we_o); else n_pass++;
      n_total++; if (bus.reg_re_o !== 1'b0) $display("FAIL rst_re got=%b exp=0", bus.reg_re_o); else n_pass++;
      n_total++; if (bus.reg_addr_o !== 20'h0) $display("FAIL rst_addr got=%h exp=0", bus.reg_addr_o); else n_pass++;
      n_total++; if (bus.reg_wdata_o !== 32'h0) $display("FAIL rst_wdata got=%h exp=0", bus.reg_wdata_o); else n_pass++;
      n_total++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy_o); else n_pass++;
      repeat (2) tick();
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_single_write();
      bus.reg_ack_i = 1'b1;
      bus.ctrl_we_i = 4'b0010;
      bus.ctrl_addr_i[1*AW +: AW]  = 20'h00010;
      bus.ctrl_wdata_i[1*DW +: DW] = 32'hA5A5A5A5;
      tick();
      idle_inputs();
      bus.reg_ack_i = 1'b1;
      n_total++; if (bus.reg_we_o !== 1'b0) $display("FAIL wr_c1_we got=%b exp=0", bus.reg_we_o); else n_pass++;
      tick();
      n_total++; if (bus.reg_we_o !== 1'b1) $display("FAIL wr_c2_we got=%b exp=1", bus.reg_we_o); else n_pass++;
      n_total++; if (bus.reg_re_o !== 1'b0) $display("FAIL wr_c2_re got=%b exp=0", bus.reg_re_o); else n_pass++;
      n_total++; if (bus.reg_addr_o !== 20'h00010) $display("FAIL wr_addr got=%h exp=00010", bus.reg_addr_o); else n_pass++;
      n_total++; if (bus.reg_wdata_o !== 32'hA5A5A5A5) $display("FAIL wr_wdata got=%h exp=a5a5a5a5", bus.reg_wdata_o); else n_pass++;
      n_total++; if (bus.busy_o !== 1'b1) $display("FAIL wr_busy got=%b exp=1", bus.busy_o); else n_pass++;
      tick();
      n_total++; if (bus.reg_we_o !== 1'b0) $display("FAIL wr_c3_we got=%b exp=0", bus.reg_we_o); else n_pass++;
      n_total++; if (bus.ctrl_ack_o !== 4'b0010) $display("FAIL wr_ack got=%b exp=0010", bus.ctrl_ack_o); else n_pass++;
      n_total++; if (bus.ctrl_err_o !== 4'b0000) $display("FAIL wr_err got=%b exp=0000", bus.ctrl_err_o); else n_pass++;
      tick();
      n_total++; if (bus.ctrl_ack_o !== 4'b0000) $display("FAIL wr_ack_len got=%b exp=0000", bus.ctrl_ack_o); else n_pass++;
      bus.reg_ack_i = 1'b0;
   endtask

   task automatic test_read();
      int              n_re;
      logic [N_CH-1:0] ack_seen;
      n_re = 0;
      ack_seen = '0;
      bus.reg_ack_i = 1'b0;
      bus.ctrl_re_i = 4'b0100;
      bus.ctrl_addr_i[2*AW +: AW] = 20'h00ABC;
      tick();
      idle_inputs();
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.reg_re_o) n_re++;
         ack_seen |= bus.ctrl_ack_o;
         if (i == 4) begin
            bus.reg_ack_i   = 1'b1;
            bus.reg_rdata_i = 32'h12345678;
         end
      end
      tick();
      bus.reg_ack_i   = 1'b0;
      bus.reg_rdata_i = '0;
      n_total++; if (n_re != 5) $display("FAIL rd_strobe_len got=%0d exp=5", n_re); else n_pass++;
      n_total++; if (ack_seen !== 4'b0000) $display("FAIL rd_early_ack got=%b exp=0000", ack_seen); else n_pass++;
      n_total++; if (bus.reg_re_o !== 1'b0) $display("FAIL rd_re_drop got=%b exp=0", bus.reg_re_o); else n_pass++;
      n_total++; if (bus.ctrl_ack_o !== 4'b0100) $display("FAIL rd_ack got=%b exp=0100", bus.ctrl_ack_o); else n_pass++;
      n_total++; if (bus.ctrl_err_o !== 4'b0000) $display("FAIL rd_err got=%b exp=0000", bus.ctrl_err_o); else n_pass++;
      n_total++; if (bus.ctrl_rdata_o !== 32'h12345678) $display("FAIL rd_rdata got=%h exp=12345678", bus.ctrl_rdata_o); else n_pass++;
   endtask

   task automatic test_timeout();
      int              n_re;
      bit              done;
      logic [N_CH-1:0] ack_c, err_c;
      logic [DW-1:0]   rd_c;
      for (int pass = 0; pass < 2; pass++) begin
         n_re = 0; done = 1'b0; ack_c = '0; err_c = '0; rd_c = '0;
         bus.reg_ack_i = 1'b0;
         bus.ctrl_re_i = 4'b0001;
         tick();
         idle_inputs();
         for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (bus.reg_re_o) begin
               n_re++;
               if (pass == 1 && n_re == TIMEOUT) begin
                  bus.reg_ack_i   = 1'b1;
                  bus.reg_rdata_i = 32'hCAFEF00D;
               end
            end
            if (bus.ctrl_ack_o != '0) begin
               done  = 1'b1;
               ack_c = bus.ctrl_ack_o;
               err_c = bus.ctrl_err_o;
               rd_c  = bus.ctrl_rdata_o;
            end
         end
         bus.reg_ack_i = 1'b0;
         n_total++; if (n_re != TIMEOUT) $display("FAIL to%0d_strobe_len got=%0d exp=%0d", pass, n_re, TIMEOUT); else n_pass++;
         n_total++; if (ack_c !== 4'b0001) $display("FAIL to%0d_ack got=%b exp=0001", pass, ack_c); else n_pass++;
         if (pass == 0) begin
            n_total++; if (err_c !== 4'b0001) $display("FAIL to0_err got=%b exp=0001", err_c); else n_pass++;
            n_total++; if (rd_c !== 32'h0) $display("FAIL to0_rdata got=%h exp=0", rd_c); else n_pass++;
         end else begin
            n_total++; if (err_c !== 4'b0000) $display("FAIL to1_err got=%b exp=0000", err_c); else n_pass++;
            n_total++; if (rd_c !== 32'hCAFEF00D) $display("FAIL to1_rdata got=%h exp=cafef00d", rd_c); else n_pass++;
         end
         tick();
         n_total++; if (bus.ctrl_err_o !== 4'b0000) $display("FAIL to%0d_err_len got=%b exp=0000", pass, bus.ctrl_err_o); else n_pass++;
      end
   endtask

   task automatic test_round_robin();
      logic [AW-1:0] a;
      bit            f;
      int            ch;
      do_reset();
      bus.reg_ack_i = 1'b1;
      bus.ctrl_we_i = 4'b1111;
      for (int c = 0; c < N_CH; c++) bus.ctrl_addr_i[c*AW +: AW] = AW'(20'h100 + c);
      tick();
      idle_inputs();
      bus.reg_ack_i = 1'b1;
      for (int cyc = 2; cyc <= 9; cyc++) begin
         tick();
         if (cyc % 2 == 0) begin
            ch = (cyc - 2) / 2;
            n_total++;
            if (bus.reg_we_o !== 1'b1 || bus.reg_addr_o !== AW'(20'h100 + ch))
               $display("FAIL rr_grant cyc=%0d got we=%b addr=%h exp we=1 addr=%h", cyc, bus.reg_we_o, bus.reg_addr_o, 20'h100 + ch);
            else n_pass++;
         end else begin
            ch = (cyc - 3) / 2;
            n_total++;
            if (bus.ctrl_ack_o !== 4'(1 << ch) || bus.reg_we_o !== 1'b0)
               $display("FAIL rr_ack cyc=%0d got ack=%b we=%b exp ack=%b we=0", cyc, bus.ctrl_ack_o, bus.reg_we_o, 4'(1 << ch));
            else n_pass++;
         end
      end
      bus.ctrl_we_i = 4'b0001;
      bus.ctrl_addr_i[0*AW +: AW] = 20'h00200;
      tick();
      bus.ctrl_we_i = '0;
      wait_grant(a, f);
      n_total++; if (!f || a !== 20'h00200) $display("FAIL rr_ch0_alone got found=%b addr=%h exp addr=00200", f, a); else n_pass++;
      tick();
      bus.ctrl_we_i = 4'b1001;
      bus.ctrl_addr_i[0*AW +: AW] = 20'h00300;
      bus.ctrl_addr_i[3*AW +: AW] = 20'h00303;
      tick();
      bus.ctrl_we_i = '0;
      wait_grant(a, f);
      n_total++; if (!f || a !== 20'h00303) $display("FAIL rr_ch3_first got found=%b addr=%h exp addr=00303", f, a); else n_pass++;
      wait_grant(a, f);
      n_total++; if (!f || a !== 20'h00300) $display("FAIL rr_ch0_second got found=%b addr=%h exp addr=00300", f, a); else n_pass++;
      repeat (2) tick();
      bus.reg_ack_i = 1'b0;
   endtask

   task automatic test_repulse();
      int n_ack, n_strobe;
      n_ack = 0; n_strobe = 0;
      bus.reg_ack_i = 1'b0;
      bus.ctrl_we_i = 4'b0010;
      bus.ctrl_addr_i[1*AW +: AW]  = 20'h0AAAA;
      bus.ctrl_wdata_i[1*DW +: DW] = 32'h11111111;
      tick();
      bus.ctrl_addr_i[1*AW +: AW]  = 20'h0BBBB;
      bus.ctrl_wdata_i[1*DW +: DW] = 32'h22222222;
      tick();
      idle_inputs();
      n_total++; if (bus.reg_we_o !== 1'b1 || bus.reg_addr_o !== 20'h0AAAA) $display("FAIL rp_first got we=%b addr=%h exp we=1 addr=0aaaa", bus.reg_we_o, bus.reg_addr_o); else n_pass++;
      n_total++; if (bus.reg_wdata_o !== 32'h11111111) $display("FAIL rp_wdata got=%h exp=11111111", bus.reg_wdata_o); else n_pass++;
      bus.reg_ack_i = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.ctrl_ack_o[1]) n_ack++;
         if (bus.reg_we_o || bus.reg_re_o) n_strobe++;
      end
      bus.reg_ack_i = 1'b0;
      n_total++; if (n_ack != 1) $display("FAIL rp_ack_count got=%0d exp=1", n_ack); else n_pass++;
      n_total++; if (n_strobe != 0) $display("FAIL rp_extra_strobe got=%0d exp=0", n_strobe); else n_pass++;
   endtask

   task automatic test_async_reset();
      int n_ack, n_strobe;
      n_ack = 0; n_strobe = 0;
      bus.reg_ack_i = 1'b0;
      bus.ctrl_re_i = 4'b0001;
      bus.ctrl_addr_i[0*AW +: AW] = 20'h00777;
      tick();
      idle_inputs();
      tick();
      n_total++; if (bus.reg_re_o !== 1'b1) $display("FAIL ar_pre_re got=%b exp=1", bus.reg_re_o); else n_pass++;
      #2;
      rstn = 1'b0;
      #1;
      n_total++; if (bus.reg_re_o !== 1'b0) $display("FAIL ar_re got=%b exp=0", bus.reg_re_o); else n_pass++;
      n_total++; if (bus.busy_o !== 1'b0) $display("FAIL ar_busy got=%b exp=0", bus.busy_o); else n_pass++;
      n_total++; if (bus.reg_addr_o !== 20'h0) $display("FAIL ar_addr got=%h exp=0", bus.reg_addr_o); else n_pass++;
      repeat (2) tick();
      rstn = 1'b1;
      bus.reg_ack_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.ctrl_ack_o != '0) n_ack++;
         if (bus.reg_we_o || bus.reg_re_o) n_strobe++;
      end
      n_total++; if (n_ack != 0) $display("FAIL ar_stale_ack got=%0d exp=0", n_ack); else n_pass++;
      n_total++; if (n_strobe != 0) $display("FAIL ar_stale_strobe got=%0d exp=0", n_strobe); else n_pass++;
      bus.ctrl_we_i = 4'b0001;
      bus.ctrl_addr_i[0*AW +: AW] = 20'h00999;
      tick();
      bus.ctrl_we_i = '0;
      tick();
      n_total++; if (bus.reg_we_o !== 1'b1 || bus.reg_addr_o !== 20'h00999) $display("FAIL ar_fresh_grant got we=%b addr=%h exp we=1 addr=00999", bus.reg_we_o, bus.reg_addr_o); else n_pass++;
      tick();
      n_total++; if (bus.ctrl_ack_o !== 4'b0001) $display("FAIL ar_fresh_ack got=%b exp=0001", bus.ctrl_ack_o); else n_pass++;
      bus.reg_ack_i = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic [N_CH-1:0] p_we, p_re, exp_ack, exp_err;
      logic [AW-1:0]   p_addr [N_CH];
      logic [DW-1:0]   p_wd   [N_CH];
      logic [DW-1:0]   m_rdata, m_rd_next;
      int              m_ptr, m_g, m_k, m_delay, g, clr_g, r;
      bit              m_busy, was_busy, m_done, m_err, ack_now;
      do_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_pend[c] = 1'b0; m_wr[c] = 1'b0; m_addr[c] = '0; m_wd[c] = '0;
         p_addr[c] = '0; p_wd[c] = '0;
      end
      p_we = '0; p_re = '0; m_rdata = '0; m_rd_next = '0;
      m_ptr = N_CH - 1; m_g = 0; m_k = 0; m_delay = 0;
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         tick();
         was_busy = m_busy;
         clr_g = -1;
         exp_ack = '0; exp_err = '0;
         if (m_done) begin
            exp_ack[m_g] = 1'b1;
            exp_err[m_g] = m_err;
            m_rdata = m_rd_next;
            m_busy = 1'b0;
            m_done = 1'b0;
            clr_g = m_g;
         end
         n_total++; if (bus.ctrl_ack_o !== exp_ack || bus.ctrl_err_o !== exp_err) $display("FAIL rnd_ack cyc=%0d got ack=%b err=%b exp ack=%b err=%b", cyc, bus.ctrl_ack_o, bus.ctrl_err_o, exp_ack, exp_err); else n_pass++;
         n_total++; if (bus.ctrl_rdata_o !== m_rdata) $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, bus.ctrl_rdata_o, m_rdata); else n_pass++;
         if (!was_busy) begin
            g = pick(m_ptr);
            if (g >= 0) begin
               m_g = g; m_ptr = g; m_busy = 1'b1; m_k = 0;
               m_delay = $urandom_range(0, TIMEOUT + 3);
            end
         end
         if (m_busy) begin
            n_total++;
            if (bus.busy_o !== 1'b1 || bus.reg_we_o !== m_wr[m_g] || bus.reg_re_o !== !m_wr[m_g] ||
                bus.reg_addr_o !== m_addr[m_g] || (m_wr[m_g] && bus.reg_wdata_o !== m_wd[m_g]))
               $display("FAIL rnd_bus cyc=%0d ch=%0d got busy=%b we=%b re=%b addr=%h wd=%h exp we=%b addr=%h wd=%h", cyc, m_g, bus.busy_o, bus.reg_we_o, bus.reg_re_o, bus.reg_addr_o, bus.reg_wdata_o, m_wr[m_g], m_addr[m_g], m_wd[m_g]);
            else n_pass++;
         end else begin
            n_total++; if (bus.busy_o !== 1'b0 || bus.reg_we_o !== 1'b0 || bus.reg_re_o !== 1'b0) $display("FAIL rnd_idle cyc=%0d got busy=%b we=%b re=%b exp 0 0 0", cyc, bus.busy_o, bus.reg_we_o, bus.reg_re_o); else n_pass++;
         end
         for (int c = 0; c < N_CH; c++) begin
            if ((p_we[c] || p_re[c]) && !m_pend[c]) begin
               m_pend[c] = 1'b1; m_wr[c] = p_we[c]; m_addr[c] = p_addr[c]; m_wd[c] = p_wd[c];
            end
         end
         if (clr_g >= 0) m_pend[clr_g] = 1'b0;
         bus.reg_rdata_i = $urandom();
         if (m_busy) begin
            ack_now = (m_k == m_delay);
            bus.reg_ack_i = ack_now;
            if (ack_now) begin
               m_done = 1'b1; m_err = 1'b0;
               m_rd_next = m_wr[m_g] ? m_rdata : bus.reg_rdata_i;
            end else if (m_k == TIMEOUT - 1) begin
               m_done = 1'b1; m_err = 1'b1;
               m_rd_next = m_wr[m_g] ? m_rdata : '0;
            end
            m_k++;
         end else begin
            bus.reg_ack_i = ($urandom_range(0, 3) == 0);
         end
         for (int c = 0; c < N_CH; c++) begin
            r = $urandom_range(0, 7);
            p_we[c] = (r == 0) || (r == 2);
            p_re[c] = (r == 1) || (r == 2);
            p_addr[c] = AW'($urandom());
            p_wd[c]   = $urandom();
            bus.ctrl_addr_i[c*AW +: AW]  = p_addr[c];
            bus.ctrl_wdata_i[c*DW +: DW] = p_wd[c];
         end
         bus.ctrl_we_i = p_we;
         bus.ctrl_re_i = p_re;
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read();
      test_timeout();
      test_round_robin();
      test_repulse();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
